// File: rtl/vx_writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vx_writeback_arbiter_pkg
//
// Purpose:
//   Shared core-configuration constants and the writeback payload type. The
//   scoreboard, the commit units and the writeback arbiter all use the same
//   payload layout, so it is defined once here.
//
// Contents:
//   NUM_WARPS / NUM_THREADS / NUM_REGS : core configuration
//   WID_W / RD_W / DATA_W              : derived field widths
//   wb_payload_t                       : one writeback beat (minus valid)
//   idx_width()                        : index width for an N-entry selector
// -----------------------------------------------------------------------------
package vx_writeback_arbiter_pkg;

    localparam int unsigned NUM_WARPS   = 4;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned NUM_REGS    = 32;

    // A single-warp core still carries a one-bit warp id.
    localparam int unsigned WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned RD_W   = $clog2(NUM_REGS);
    localparam int unsigned DATA_W = NUM_THREADS * 32;

    typedef struct packed {
        logic [WID_W-1:0]       wid;
        logic [31:0]            pc;
        logic [NUM_THREADS-1:0] tmask;
        logic [RD_W-1:0]        rd;
        logic [DATA_W-1:0]      data;
        logic                   eop;
    } wb_payload_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_writeback_arbiter_rr_lock.sv
// -----------------------------------------------------------------------------
// vx_writeback_arbiter_rr_lock
//
// Purpose:
//   Combinational N-way round-robin arbiter with lock-hold. While i_lock is
//   set the grant is pinned to i_lock_idx whether or not that requester is
//   currently valid. Otherwise the first requester found scanning upward from
//   i_rr_ptr+1 (wrapping modulo N) wins. Holds no state; the owner keeps the
//   lock and pointer registers.
//
// Ports:
//   i_requests     [N]      per-requester request
//   i_lock                  grant is pinned to i_lock_idx
//   i_lock_idx     [IDX_W]  pinned index
//   i_rr_ptr       [IDX_W]  index granted last; its successor has priority
//   o_grant_valid           a grant exists
//   o_grant_idx    [IDX_W]  granted index (0 when no grant)
//   o_grant_onehot [N]      granted index, one-hot (all 0 when no grant)
// -----------------------------------------------------------------------------
module vx_writeback_arbiter_rr_lock
    import vx_writeback_arbiter_pkg::*;
#(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_requests,
    input  logic             i_lock,
    input  logic [IDX_W-1:0] i_lock_idx,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic [N-1:0]     o_grant_onehot
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant_valid  = 1'b0;
        o_grant_idx    = '0;
        o_grant_onehot = '0;
        w_cand         = '0;

        if (i_lock) begin
            o_grant_valid              = 1'b1;
            o_grant_idx                = i_lock_idx;
            o_grant_onehot[i_lock_idx] = 1'b1;
        end else begin
            // Offsets 1..N visit every index once, ending on i_rr_ptr itself.
            for (int unsigned off = 1; off <= N; off++) begin
                w_cand = wrap_add(i_rr_ptr, off);
                if (!o_grant_valid && i_requests[w_cand]) begin
                    o_grant_valid          = 1'b1;
                    o_grant_idx            = w_cand;
                    o_grant_onehot[w_cand] = 1'b1;
                end
            end
        end
    end

    // (base + off) mod N for base < N and off <= N.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDX_W'(sum);
    endfunction

endmodule

// File: rtl/vx_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// vx_writeback_arbiter
//
// Purpose:
//   Shares the core writeback port among NUM_REQS commit ports. One requester
//   is chosen per packet by round-robin and keeps the grant until its
//   end-of-packet beat is accepted. The accepted beat is registered into a
//   one-entry elastic stage that drives the register-file write and the
//   scoreboard release. A beat accepted in cycle N is visible in cycle N+1;
//   the stage accepts a new beat in the same cycle it drains, so sustained
//   throughput is one beat per cycle.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_req_valid / o_req_ready [R]    per-requester beat handshake
//   i_req_wid/pc/tmask/rd/data/eop   per-requester beat payload, flattened
//   o_wb_valid / i_wb_ready          writeback handshake
//   o_wb_wid/pc/tmask/rd/data/eop    registered payload of the accepted beat
//   o_perf_stalls [32]               cycles with a request but no acceptance
// -----------------------------------------------------------------------------
module vx_writeback_arbiter
    import vx_writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,

    input  logic [NUM_REQS-1:0]             i_req_valid,
    output logic [NUM_REQS-1:0]             o_req_ready,
    input  logic [NUM_REQS*WID_W-1:0]       i_req_wid,
    input  logic [NUM_REQS*32-1:0]          i_req_pc,
    input  logic [NUM_REQS*NUM_THREADS-1:0] i_req_tmask,
    input  logic [NUM_REQS*RD_W-1:0]        i_req_rd,
    input  logic [NUM_REQS*DATA_W-1:0]      i_req_data,
    input  logic [NUM_REQS-1:0]             i_req_eop,

    output logic                            o_wb_valid,
    input  logic                            i_wb_ready,
    output logic [WID_W-1:0]                o_wb_wid,
    output logic [31:0]                     o_wb_pc,
    output logic [NUM_THREADS-1:0]          o_wb_tmask,
    output logic [RD_W-1:0]                 o_wb_rd,
    output logic [DATA_W-1:0]               o_wb_data,
    output logic                            o_wb_eop,

    output logic [31:0]                     o_perf_stalls
);

    localparam int unsigned IDX_W = idx_width(NUM_REQS);

    // Arbitration state
    logic             r_locked;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_rr_ptr;

    // Output stage
    logic             r_wb_valid;
    wb_payload_t      r_wb;
    logic [31:0]      r_perf_stalls;

    // Grant and handshake
    logic                w_grant_valid;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [NUM_REQS-1:0] w_grant_onehot;
    logic                w_stage_ready;
    logic                w_fire;
    wb_payload_t         w_sel;

    vx_writeback_arbiter_rr_lock #(
        .N     (NUM_REQS),
        .IDX_W (IDX_W)
    ) u_rr_lock (
        .i_requests     (i_req_valid),
        .i_lock         (r_locked),
        .i_lock_idx     (r_lock_idx),
        .i_rr_ptr       (r_rr_ptr),
        .o_grant_valid  (w_grant_valid),
        .o_grant_idx    (w_grant_idx),
        .o_grant_onehot (w_grant_onehot)
    );

    assign w_stage_ready = !r_wb_valid || i_wb_ready;

    // Reset gates ready directly: the stage looks empty during reset, but
    // nothing may be accepted until reset is released.
    assign o_req_ready = (w_grant_valid && w_stage_ready && i_rst_n) ? w_grant_onehot : '0;

    // o_req_ready is one-hot, so this is valid[grant] && ready[grant].
    assign w_fire = |(i_req_valid & o_req_ready);

    // Payload mux driven by the one-hot grant.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (w_grant_onehot[i]) begin
                w_sel.wid   = i_req_wid[i*WID_W +: WID_W];
                w_sel.pc    = i_req_pc[i*32 +: 32];
                w_sel.tmask = i_req_tmask[i*NUM_THREADS +: NUM_THREADS];
                w_sel.rd    = i_req_rd[i*RD_W +: RD_W];
                w_sel.data  = i_req_data[i*DATA_W +: DATA_W];
                w_sel.eop   = i_req_eop[i];
            end
        end
    end

    // Lock / round-robin state. rr_ptr resets to the last index so index 0
    // has first priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= IDX_W'(NUM_REQS - 1);
        end else if (w_fire) begin
            if (w_sel.eop) begin
                r_locked <= 1'b0;
                r_rr_ptr <= w_grant_idx;
            end else begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_grant_idx;
            end
        end
    end

    // Elastic output stage: load on acceptance, empty on drain, hold otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
        end else if (w_fire) begin
            r_wb_valid <= 1'b1;
            r_wb       <= w_sel;
        end else if (i_wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    // Wraps naturally at 2^32.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_stalls <= '0;
        end else if (|i_req_valid && !w_fire) begin
            r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign o_wb_valid    = r_wb_valid;
    assign o_wb_wid      = r_wb.wid;
    assign o_wb_pc       = r_wb.pc;
    assign o_wb_tmask    = r_wb.tmask;
    assign o_wb_rd       = r_wb.rd;
    assign o_wb_data     = r_wb.data;
    assign o_wb_eop      = r_wb.eop;
    assign o_perf_stalls = r_perf_stalls;

    // -------------------------------------------------------------------------
    // Checkers. The idle counter has no functional fanout and is removed by
    // synthesis; it only feeds the deadlock assertion.
    // -------------------------------------------------------------------------
    logic        w_owner_idle;
    logic [13:0] r_idle_cnt;

    assign w_owner_idle = r_locked && |(w_grant_onehot & ~i_req_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_owner_idle) begin
            if (r_idle_cnt != '1) begin
                r_idle_cnt <= r_idle_cnt + 14'd1;
            end
        end else begin
            r_idle_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (r_idle_cnt <= 14'd10000)
            else $error("writeback lock owner %0d idle for over 10000 cycles", r_lock_idx);
        end
    end

    // A raised request must be held until it is accepted.
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_valid_hold
        assert property (@(posedge i_clk) disable iff (!i_rst_n)
                         (i_req_valid[g] && !o_req_ready[g]) |=> i_req_valid[g])
        else $error("requester %0d dropped valid before acceptance", g);
    end

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
module tb_vx_writeback_arbiter;
    import vx_writeback_arbiter_pkg::*;

    localparam int NR = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NR-1:0]             req_valid;
    logic [NR-1:0]             req_ready;
    logic [NR*WID_W-1:0]       req_wid;
    logic [NR*32-1:0]          req_pc;
    logic [NR*NUM_THREADS-1:0] req_tmask;
    logic [NR*RD_W-1:0]        req_rd;
    logic [NR*DATA_W-1:0]      req_data;
    logic [NR-1:0]             req_eop;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [WID_W-1:0]          wb_wid;
    logic [31:0]               wb_pc;
    logic [NUM_THREADS-1:0]    wb_tmask;
    logic [RD_W-1:0]           wb_rd;
    logic [DATA_W-1:0]         wb_data;
    logic                      wb_eop;
    logic [31:0]               perf_stalls;

    always #5 clk = ~clk;

    vx_writeback_arbiter #(
        .NUM_REQS (NR)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_wid     (req_wid),
        .i_req_pc      (req_pc),
        .i_req_tmask   (req_tmask),
        .i_req_rd      (req_rd),
        .i_req_data    (req_data),
        .i_req_eop     (req_eop),
        .o_wb_valid    (wb_valid),
        .i_wb_ready    (wb_ready),
        .o_wb_wid      (wb_wid),
        .o_wb_pc       (wb_pc),
        .o_wb_tmask    (wb_tmask),
        .o_wb_rd       (wb_rd),
        .o_wb_data     (wb_data),
        .o_wb_eop      (wb_eop),
        .o_perf_stalls (perf_stalls)
    );

    // Stimulus sources, scoreboard and output log (requester id per drained beat)
    wb_payload_t src_q [NR][$];
    wb_payload_t exp_q [$];
    int          log_q [$];

    int n_checks = 0;
    int n_fails  = 0;
    int seq_no   = 0;

    // Reference model state
    bit          m_locked;
    int          m_lock_idx;
    int          m_rr_ptr;
    bit          m_wb_valid;
    logic [31:0] m_stalls;
    bit          tb_wb_ready;

    // Output hold tracking across a stalled cycle
    bit           stall_prev;
    logic [31:0]  hold_pc;
    logic [127:0] hold_data;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_lock_idx = 0;
        m_rr_ptr   = NR - 1;
        m_wb_valid = 1'b0;
        m_stalls   = '0;
        stall_prev = 1'b0;
    endtask

    function automatic wb_payload_t mk_beat(input int src, input bit eop);
        wb_payload_t p;
        p.wid   = WID_W'($urandom);
        p.pc    = {4'(src), 28'(seq_no)};
        p.tmask = NUM_THREADS'($urandom);
        p.rd    = RD_W'($urandom);
        p.data  = {$urandom, $urandom, $urandom, $urandom};
        p.eop   = eop;
        seq_no++;
        return p;
    endfunction

    task automatic push_pkt(input int src, input int beats);
        for (int b = 0; b < beats; b++) begin
            src_q[src].push_back(mk_beat(src, b == beats - 1));
        end
    endtask

    task automatic drive();
        wb_payload_t p;
        for (int i = 0; i < NR; i++) begin
            p = '0;
            req_valid[i] = 1'b0;
            if (src_q[i].size() > 0) begin
                p = src_q[i][0];
                req_valid[i] = 1'b1;
            end
            req_wid[i*WID_W +: WID_W]                   = p.wid;
            req_pc[i*32 +: 32]                          = p.pc;
            req_tmask[i*NUM_THREADS +: NUM_THREADS]     = p.tmask;
            req_rd[i*RD_W +: RD_W]                      = p.rd;
            req_data[i*DATA_W +: DATA_W]                = p.data;
            req_eop[i]                                  = p.eop;
        end
        wb_ready = tb_wb_ready;
    endtask

    function automatic int model_grant();
        int idx;
        if (m_locked) return m_lock_idx;
        for (int off = 1; off <= NR; off++) begin
            idx = (m_rr_ptr + off) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit busy();
        bit b = m_wb_valid;
        for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    // One clock cycle: drive at negedge, check mid-cycle, update model at posedge.
    task automatic step();
        int            g;
        bit            stage_rdy;
        bit            fire;
        logic [NR-1:0] exp_ready;
        wb_payload_t   e;
        wb_payload_t   beat;

        drive();
        #1;
        g         = model_grant();
        stage_rdy = !m_wb_valid || tb_wb_ready;
        exp_ready = '0;
        if (g >= 0 && stage_rdy) exp_ready[g] = 1'b1;
        fire = (g >= 0) && req_valid[g] && stage_rdy;
        beat = '0;
        if (fire) beat = src_q[g][0];

        check_eq("req_ready", 128'(req_ready), 128'(exp_ready));
        check_eq("wb_valid", 128'(wb_valid), 128'(m_wb_valid));
        check_eq("perf_stalls", 128'(perf_stalls), 128'(m_stalls));
        if (stall_prev) begin
            check_eq("hold_pc", 128'(wb_pc), 128'(hold_pc));
            check_eq("hold_data", 128'(wb_data), hold_data);
        end
        if (m_wb_valid && tb_wb_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("scoreboard_empty", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_pc", 128'(wb_pc), 128'(e.pc));
                check_eq("wb_wid", 128'(wb_wid), 128'(e.wid));
                check_eq("wb_tmask", 128'(wb_tmask), 128'(e.tmask));
                check_eq("wb_rd", 128'(wb_rd), 128'(e.rd));
                check_eq("wb_data", 128'(wb_data), 128'(e.data));
                check_eq("wb_eop", 128'(wb_eop), 128'(e.eop));
            end
            log_q.push_back(int'(wb_pc[31:28]));
        end
        stall_prev = m_wb_valid && !tb_wb_ready;
        hold_pc    = wb_pc;
        hold_data  = 128'(wb_data);
        if (fire) exp_q.push_back(beat);

        @(posedge clk);
        if (|req_valid && !fire) m_stalls = m_stalls + 32'd1;
        if (fire) begin
            m_wb_valid = 1'b1;
            if (beat.eop) begin
                m_locked = 1'b0;
                m_rr_ptr = g;
            end else begin
                m_locked   = 1'b1;
                m_lock_idx = g;
            end
            void'(src_q[g].pop_front());
        end else if (tb_wb_ready) begin
            m_wb_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        tb_wb_ready = 1'b1;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_timeout", 128'(busy()), 128'(0));
    endtask

    task automatic check_order(input string tag, input int n,
                               input int a0, input int a1, input int a2,
                               input int a3, input int a4);
        int e[5] = '{a0, a1, a2, a3, a4};
        check_eq({tag, "_len"}, 128'(log_q.size()), 128'(n));
        for (int k = 0; k < n; k++) begin
            check_eq(tag, 128'((k < log_q.size()) ? log_q[k] : 99), 128'(e[k]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]  s0;
        logic [31:0]  pc_hold;
        wb_payload_t  b1;

        rst_n       = 1'b0;
        tb_wb_ready = 1'b1;
        req_valid   = '0;
        model_reset();

        // Reset state, with all three requesters already presenting beats
        push_pkt(0, 1);
        push_pkt(1, 1);
        push_pkt(2, 1);
        push_pkt(0, 1);
        drive();
        @(negedge clk);
        #1;
        check_eq("rst_req_ready", 128'(req_ready), 128'(0));
        check_eq("rst_wb_valid", 128'(wb_valid), 128'(0));
        check_eq("rst_wb_pc", 128'(wb_pc), 128'(0));
        check_eq("rst_wb_data", 128'(wb_data), 128'(0));
        check_eq("rst_wb_misc", 128'({wb_wid, wb_tmask, wb_rd, wb_eop}), 128'(0));
        check_eq("rst_perf", 128'(perf_stalls), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all valid, single-beat packets
        log_q.delete();
        run_until_idle(50);
        check_order("rr_order", 4, 0, 1, 2, 0, 0);

        // Packet lock: req1 three-beat packet interleaved with nothing
        log_q.delete();
        push_pkt(0, 1);
        push_pkt(1, 3);
        push_pkt(2, 1);
        run_until_idle(50);
        check_order("lock_order", 5, 1, 1, 1, 2, 0);

        // Backpressure for 4 cycles, then load-while-drain
        log_q.delete();
        push_pkt(0, 1);
        push_pkt(0, 1);
        b1 = src_q[0][1];
        tb_wb_ready = 1'b0;
        step();
        s0      = perf_stalls;
        pc_hold = wb_pc;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("bp_req_ready", 128'(req_ready), 128'(0));
            check_eq("bp_pc_stable", 128'(wb_pc), 128'(pc_hold));
        end
        check_eq("bp_stall_delta", 128'(perf_stalls - s0), 128'(4));
        tb_wb_ready = 1'b1;
        step();
        check_eq("lwd_wb_valid", 128'(wb_valid), 128'(1));
        check_eq("lwd_wb_pc", 128'(wb_pc), 128'(b1.pc));
        run_until_idle(20);
        check_order("bp_order", 2, 0, 0, 0, 0, 0);

        // Lock hold while owner is idle
        log_q.delete();
        push_pkt(0, 2);
        src_q[0].pop_back();
        step();
        push_pkt(1, 1);
        s0 = perf_stalls;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("idle_ready1", 128'(req_ready[1]), 128'(0));
        end
        check_eq("idle_stall_delta", 128'(perf_stalls - s0), 128'(5));
        src_q[0].push_back(mk_beat(0, 1'b1));
        run_until_idle(20);
        check_order("idle_order", 3, 0, 0, 1, 0, 0);

        // Random traffic with multi-beat packets and random backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
                    push_pkt(i, int'($urandom_range(1, 3)));
                end
            end
            tb_wb_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        run_until_idle(300);

        // Asynchronous reset between beats of a locked packet
        push_pkt(0, 2);
        src_q[0].pop_back();
        step();
        push_pkt(1, 1);
        tb_wb_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        req_valid = '0;
        #1;
        check_eq("arst_wb_valid", 128'(wb_valid), 128'(0));
        check_eq("arst_wb_pc", 128'(wb_pc), 128'(0));
        check_eq("arst_req_ready", 128'(req_ready), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        log_q.delete();
        tb_wb_ready = 1'b1;
        #1;
        check_eq("arst_perf", 128'(perf_stalls), 128'(0));
        @(negedge clk);
        push_pkt(2, 1);
        push_pkt(0, 1);
        run_until_idle(20);
        check_order("arst_order", 2, 0, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
